// File: rtl/result_sel_unit.sv
// Result multiplexer with per-source holding buffers, RISC-V load extraction/extension
// and a one-deep registered valid/ready output stage feeding register-file writeback.
module result_sel_unit #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC*WIDTH-1:0]   src_in,
   input  logic [NUM_SRC-1:0]         buf_en,
   input  logic [SEL_W-1:0]           src_sel,
   input  logic                       use_buf,
   input  logic [2:0]                 ext_mode,
   input  logic [1:0]                 byte_off,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       flush,
   output logic [WIDTH-1:0]           result,
   output logic                       result_valid,
   input  logic                       result_ready,
   output logic                       sel_err
);

   localparam logic [2:0] MODE_LB  = 3'b000;
   localparam logic [2:0] MODE_LH  = 3'b001;
   localparam logic [2:0] MODE_LW  = 3'b010;
   localparam logic [2:0] MODE_LBU = 3'b100;
   localparam logic [2:0] MODE_LHU = 3'b101;

   logic [WIDTH-1:0]   src_slice [NUM_SRC];
   logic [WIDTH-1:0]   buf_q     [NUM_SRC];
   logic [WIDTH-1:0]   buf_d     [NUM_SRC];
   logic [NUM_SRC-1:0] sel_hit;

   // Per-source holding buffers; they run independently of the handshake and flush.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_slice[gi] = src_in[gi*WIDTH +: WIDTH];
      assign sel_hit[gi]   = (src_sel == SEL_W'(gi));

      always_comb begin
         buf_d[gi] = buf_q[gi];
         if (buf_en[gi]) begin
            buf_d[gi] = src_slice[gi];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            buf_q[gi] <= '0;
         end else begin
            buf_q[gi] <= buf_d[gi];
         end
      end
   end

   logic             sel_valid;
   logic [WIDTH-1:0] raw;

   // Buffer reads use the pre-edge value, so a same-cycle capture is seen one cycle later.
   always_comb begin
      raw = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel_hit[i]) begin
            raw = use_buf ? buf_q[i] : src_slice[i];
         end
      end
   end

   assign sel_valid = |sel_hit;

   logic [7:0]       byte_val;
   logic [15:0]      half_val;
   logic [WIDTH-1:0] ext_val;

   always_comb begin
      byte_val = raw[7:0];
      case (byte_off)
         2'd0:    byte_val = raw[7:0];
         2'd1:    byte_val = raw[15:8];
         2'd2:    byte_val = raw[23:16];
         default: byte_val = raw[31:24];
      endcase
      half_val = byte_off[1] ? raw[31:16] : raw[15:0];
   end

   always_comb begin
      ext_val = raw;
      case (ext_mode)
         MODE_LB:  ext_val = {{(WIDTH-8){byte_val[7]}}, byte_val};
         MODE_LBU: ext_val = {{(WIDTH-8){1'b0}}, byte_val};
         MODE_LH:  ext_val = {{(WIDTH-16){half_val[15]}}, half_val};
         MODE_LHU: ext_val = {{(WIDTH-16){1'b0}}, half_val};
         MODE_LW:  ext_val = raw;
         default:  ext_val = raw;
      endcase
   end

   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             sel_err_q, sel_err_d;
   logic             accept;

   assign req_ready = !result_valid_q || result_ready;
   assign accept    = req_valid && req_ready && !flush;

   // Flush wins over both a new accept and a pending output; result data is never cleared.
   always_comb begin
      result_d       = result_q;
      result_valid_d = result_valid_q;
      sel_err_d      = 1'b0;
      if (flush) begin
         result_valid_d = 1'b0;
      end else if (accept) begin
         result_d       = ext_val;
         result_valid_d = 1'b1;
         sel_err_d      = !sel_valid;
      end else if (result_valid_q && result_ready) begin
         result_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q       <= '0;
         result_valid_q <= 1'b0;
         sel_err_q      <= 1'b0;
      end else begin
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         sel_err_q      <= sel_err_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign sel_err      = sel_err_q;

endmodule

// File: doc/result_sel_unit.md
Name: result_sel_unit

Overview:
- Parametrised successor of the CPU result multiplexer.
- Holds the per-source holding registers internally: ALU result buffer, memory data buffer, and any further sources.
- Selects a live or buffered source and applies RISC-V load extraction and extension (LB/LH/LW/LBU/LHU).
- Delivers the result through a one-deep registered valid/ready stage to register-file writeback.

Parameters:
- WIDTH, 32, datapath width; must be >= 32.
- NUM_SRC, 4, number of result sources.
- SEL_W, 2, select width; 2^SEL_W >= NUM_SRC required.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_in  in  NUM_SRC*WIDTH  concatenated sources; source i = bits [i*WIDTH +: WIDTH].
- buf_en  in  NUM_SRC  bit i captures source i into buffer i at the edge.
- src_sel  in  SEL_W  source index.
- use_buf  in  1  1 = take buffer[src_sel], 0 = take live src_in slice.
- ext_mode  in  3  funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes pass through.
- byte_off  in  2  address low bits for byte/half extraction.
- req_valid  in  1  request to produce a result.
- req_ready  out  1  stage can accept a request.
- flush  in  1  discard the pending result.
- result  out  WIDTH  registered result.
- result_valid  out  1  result holds valid data.
- result_ready  in  1  consumer accepts result.
- sel_err  out  1  registered; 1 for one cycle after accepting a request with src_sel >= NUM_SRC.

Behaviour:
- Reset (async, immediate): all buffers = 0, result = 0, result_valid = 0, sel_err = 0. Reset mid-transfer drops the pending result; no replay.
- Buffers:
  - buf_en[i] loads src_in slice i at the edge.
  - Buffers are independent of the handshake, flush and acceptance.
- Selection is combinational from pre-edge state: raw = use_buf ? buffer[src_sel] : src_in[src_sel].
  - If buf_en[src_sel] and use_buf are asserted in the same cycle, raw is the OLD buffer value; the new value is visible from the next cycle.
  - src_sel >= NUM_SRC: raw = 0.
- Extension, applied to raw:
  - LB/LBU: byte raw[8*byte_off +: 8], sign- or zero-extended to WIDTH.
  - LH/LHU: half raw[16*byte_off[1] +: 16], extended; byte_off[0] ignored.
  - LW and all other codes: raw unchanged; byte_off ignored.
- Handshake:
  - req_ready = !result_valid || result_ready (combinational; no req_valid dependence).
  - Accept = req_valid && req_ready && !flush. On accept: result <= extended value, result_valid <= 1. Latency 1 cycle.
  - Output accepted (result_valid && result_ready) with no new accept: result_valid <= 0; result holds its last value.
  - Simultaneous output accept and new request: back-to-back, result_valid stays 1 and result updates. Full throughput, one per cycle.
  - result and result_valid are stable while result_valid && !result_ready.
- flush has priority over everything except reset:
  - result_valid <= 0 and any same-cycle request is dropped.
  - result keeps its value; sel_err <= 0.
- sel_err <= 1 only on an accept with an invalid src_sel; otherwise 0.

Test Plan:
- Reset, then no stimulus -> result = 0, result_valid = 0, req_ready = 1, sel_err = 0.
- Buffer path: buf_en[1] = 1 with src_in[1] = 0x1234_5678 in cycle 0; cycle 1: use_buf = 1, src_sel = 1, ext_mode = 010, req_valid = 1 -> cycle 2: result = 0x1234_5678, result_valid = 1.
- Same-cycle capture: buffer[0] = 0xAAAA_AAAA, then buf_en[0] = 1 with src_in[0] = 0x5555_5555 and a request with use_buf = 1, src_sel = 0 -> result = 0xAAAA_AAAA. Next request -> 0x5555_5555.
- Extension on raw 0x80FF_7F80:
  - LB, byte_off 0 -> 0xFFFF_FF80.
  - LBU, byte_off 1 -> 0x0000_007F.
  - LH, byte_off 2 -> 0xFFFF_80FF.
  - LHU, byte_off 3 -> 0x0000_80FF.
- Backpressure and flush:
  - Hold result_ready = 0 with result_valid = 1 for 3 cycles -> req_ready = 0, result stable.
  - Raise result_ready with req_valid = 1 -> new result the next cycle, no gap.
  - Assert flush with req_valid = 1 -> result_valid = 0 the next cycle, request dropped.
- Invalid select: NUM_SRC = 3, src_sel = 3, request accepted -> result = 0, result_valid = 1, sel_err = 1 for exactly one cycle.
